// File: rtl/uc_pkg.sv
// Shared types for the universal counter: boundary modes and run/halt state.
package uc_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/uc_next_calc.sv
// Combinational next-count and boundary-event calculation.
module uc_next_calc
  import uc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] nxt,
  output logic             event_hit
);

  logic [WIDTH:0] q_x;
  logic [WIDTH:0] st_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] span;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] raw;

  // One extra bit keeps q+step and q+limit+1 free of overflow.
  assign q_x   = {1'b0, q};
  assign st_x  = {1'b0, step};
  assign lim_x = {1'b0, limit};
  assign span  = lim_x + 1'b1;
  assign sum   = q_x + st_x;

  always_comb begin
    raw       = q_x;
    event_hit = 1'b0;
    if (step != '0) begin
      if (up_down) begin
        event_hit = sum > lim_x;
        raw       = sum;
        if (event_hit) begin
          unique case (mode)
            MODE_SAT,
            MODE_ONESHOT: raw = lim_x;
            MODE_WRAP,
            MODE_RSVD:    raw = sum - span;
          endcase
        end
      end else begin
        event_hit = q_x < st_x;
        raw       = q_x - st_x;
        if (event_hit) begin
          unique case (mode)
            MODE_SAT,
            MODE_ONESHOT: raw = '0;
            MODE_WRAP,
            MODE_RSVD:    raw = q_x + span - st_x;
          endcase
        end
      end
    end
    nxt = raw[WIDTH-1:0];
  end

endmodule

// File: rtl/param_universal_counter.sv
// Parametrised up/down counter with limit, step, wrap/sat/one-shot
// boundary handling, terminal-count pulse and sticky boundary flag.
module param_universal_counter
  import uc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_en,
  input  logic             count_en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] q_out,
  output logic             tc,
  output logic             wrap_flag,
  output logic             busy
);

  cnt_state_e       state;
  cnt_mode_e        md;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] clamp;
  logic             event_hit;
  logic             do_count;
  logic             fire;

  assign md       = cnt_mode_e'(mode);
  assign clamp    = (data_in > limit) ? limit : data_in;
  assign do_count = !load_en && count_en && (state == ST_RUN);
  assign fire     = do_count && event_hit;
  assign busy     = (state == ST_RUN);

  uc_next_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .q        (q_out),
    .step     (step),
    .limit    (limit),
    .up_down  (up_down),
    .mode     (md),
    .nxt      (nxt),
    .event_hit(event_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      q_out     <= RESET_VAL;
      tc        <= 1'b0;
      wrap_flag <= 1'b0;
      state     <= ST_RUN;
    end else begin
      tc <= 1'b0;
      if (load_en) begin
        q_out <= clamp;
        state <= ST_RUN;
      end else if (do_count) begin
        q_out <= nxt;
        tc    <= event_hit;
        if (event_hit && md == MODE_ONESHOT)
          state <= ST_HALT;
      end else if (state == ST_HALT && md != MODE_ONESHOT) begin
        state <= ST_RUN;
      end
      // A set on the same edge as a clear must win.
      if (fire)
        wrap_flag <= 1'b1;
      else if (clr_flag)
        wrap_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_universal_counter.sv
// Directed plan plus randomized run against an integer reference model.
module tb_param_universal_counter;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_en;
  logic         count_en;
  logic         up_down;
  logic [W-1:0] step;
  logic [W-1:0] limit;
  logic [1:0]   mode;
  logic         clr_flag;
  logic [W-1:0] q_out;
  logic         tc;
  logic         wrap_flag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int m_q    = 0;
  int m_tc   = 0;
  int m_flag = 0;
  int m_run  = 1;

  param_universal_counter #(
    .WIDTH    (W),
    .RESET_VAL(8'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load_en  (load_en),
    .count_en (count_en),
    .up_down  (up_down),
    .step     (step),
    .limit    (limit),
    .mode     (mode),
    .clr_flag (clr_flag),
    .q_out    (q_out),
    .tc       (tc),
    .wrap_flag(wrap_flag),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one edge of the counter expressed with plain integers.
  task automatic model(input int r, ld, ce, ud, cf, d, st, lim, md);
    int ev;
    int oneshot;
    int sat;
    ev      = 0;
    oneshot = (md == 2);
    sat     = (md == 1) || oneshot;
    if (r) begin
      m_q = 0; m_tc = 0; m_flag = 0; m_run = 1;
      return;
    end
    if (ld) begin
      m_q   = (d > lim) ? lim : d;
      m_run = 1;
    end else if (ce && m_run) begin
      if (st != 0 && ud && m_q + st > lim) begin
        ev  = 1;
        m_q = sat ? lim : m_q + st - (lim + 1);
      end else if (st != 0 && !ud && m_q < st) begin
        ev  = 1;
        m_q = sat ? 0 : m_q + (lim + 1) - st;
      end else begin
        m_q = ud ? m_q + st : m_q - st;
      end
      m_q = m_q % 256;
      if (ev && oneshot) m_run = 0;
    end else if (!m_run && !oneshot) begin
      m_run = 1;
    end
    m_tc   = ev;
    m_flag = ev ? 1 : (cf ? 0 : m_flag);
  endtask

  task automatic cyc(input int r, ld, ce, ud, cf, d, st, lim, md);
    reset    = r[0];
    load_en  = ld[0];
    count_en = ce[0];
    up_down  = ud[0];
    clr_flag = cf[0];
    data_in  = d[W-1:0];
    step     = st[W-1:0];
    limit    = lim[W-1:0];
    mode     = md[1:0];
    @(posedge clk);
    model(r, ld, ce, ud, cf, d, st, lim, md);
    #1;
    check("q_out", int'(q_out), m_q);
    check("tc", int'(tc), m_tc);
    check("wrap_flag", int'(wrap_flag), m_flag);
    check("busy", int'(busy), m_run);
  endtask

  initial begin
    int lim;
    int st;
    int md;
    cyc(1, 1, 1, 1, 0, 5, 1, 9, 0);
    cyc(1, 1, 1, 1, 0, 5, 1, 9, 0);
    check("rst_q", int'(q_out), 0);
    check("rst_busy", int'(busy), 1);
    repeat (7) cyc(0, 0, 1, 1, 0, 0, 1, 9, 0);
    check("mid_q7", int'(q_out), 7);
    cyc(1, 0, 1, 1, 0, 0, 1, 9, 0);
    check("mid_rst", int'(q_out), 0);

    repeat (10) cyc(0, 0, 1, 1, 0, 0, 1, 9, 0);
    check("wrap_q0", int'(q_out), 0);
    check("wrap_tc", int'(tc), 1);
    check("wrap_flg", int'(wrap_flag), 1);
    cyc(0, 1, 0, 1, 0, 8, 4, 9, 0);
    cyc(0, 0, 1, 1, 0, 0, 4, 9, 0);
    check("wrap_s4", int'(q_out), 2);

    cyc(0, 1, 0, 0, 0, 1, 3, 9, 0);
    cyc(0, 0, 1, 0, 0, 0, 3, 9, 0);
    check("wrap_dn", int'(q_out), 8);
    cyc(0, 1, 0, 0, 0, 3, 2, 9, 1);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 2, 9, 1);
    check("sat_q", int'(q_out), 0);
    check("sat_tc", int'(tc), 1);

    cyc(0, 1, 0, 1, 0, 0, 2, 5, 2);
    repeat (3) cyc(0, 0, 1, 1, 0, 0, 2, 5, 2);
    check("os_q", int'(q_out), 5);
    check("os_busy", int'(busy), 0);
    cyc(0, 0, 1, 1, 0, 0, 2, 5, 2);
    check("os_hold", int'(q_out), 5);
    cyc(0, 1, 0, 1, 0, 1, 2, 5, 2);
    check("os_load", int'(q_out), 1);
    check("os_run", int'(busy), 1);

    cyc(0, 1, 1, 1, 0, 200, 1, 99, 0);
    check("clamp", int'(q_out), 99);
    cyc(0, 0, 1, 1, 0, 0, 1, 50, 0);
    check("lim_chg", int'(q_out), 49);

    cyc(0, 0, 1, 1, 1, 0, 2, 50, 0);
    check("flg_set", int'(wrap_flag), 1);
    cyc(0, 0, 1, 1, 1, 0, 1, 50, 0);
    check("flg_clr", int'(wrap_flag), 0);

    lim = 9; st = 1; md = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) lim = $urandom_range(0, 254);
      if ($urandom_range(0, 7) == 0) md = $urandom_range(0, 3);
      st = $urandom_range(0, lim + 1);
      cyc(($urandom_range(0, 99) == 0) ? 1 : 0,
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0) ? 1 : 0,
          $urandom_range(0, 255), st, lim, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
